// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (instruction fetch / data) for a single unified memory.
// Each access holds the memory lines for ACC_CYCLES clocks, then acks the winner for one cycle.
module mem_port_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int ACC_CYCLES = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic [1:0]        d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_read,
   output logic [1:0]        mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wdata_oe,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant_id
);
   localparam int CNT_W = (ACC_CYCLES > 2) ? $clog2(ACC_CYCLES) : 1;
   localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [STV_W-1:0]  r_starve;
   logic              r_gid;
   logic              r_busy;
   logic              r_f_ack;
   logic              r_d_ack;
   logic [DATA_W-1:0] r_f_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_mem_read;
   logic [1:0]        r_mem_write;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_oe;

   logic w_d_write;
   logic w_grant_data;
   logic w_grant_fetch;

   // Data wins ties unless fetch has already been passed over STARVE_MAX times in a row.
   always_comb begin
      w_d_write     = (d_we == 2'd1) || (d_we == 2'd3);
      w_grant_data  = d_req && (!f_req || (r_starve != STV_MAX));
      w_grant_fetch = f_req && !w_grant_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_starve    <= '0;
         r_gid       <= 1'b0;
         r_busy      <= 1'b0;
         r_f_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_f_rdata   <= '0;
         r_d_rdata   <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 2'd0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_oe    <= 1'b0;
      end else begin
         r_f_ack <= 1'b0;
         r_d_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_data || w_grant_fetch) begin
                  r_state    <= ACCESS;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_gid      <= w_grant_data;
                  r_mem_addr <= w_grant_data ? d_addr : f_addr;
                  if (w_grant_data && w_d_write) begin
                     r_mem_read  <= 1'b0;
                     r_mem_write <= d_we;
                     r_mem_wdata <= d_wdata;
                     r_mem_oe    <= 1'b1;
                  end else begin
                     r_mem_read  <= 1'b1;
                     r_mem_write <= 2'd0;
                     r_mem_wdata <= '0;
                     r_mem_oe    <= 1'b0;
                  end
                  // A data grant with fetch waiting can only happen below STV_MAX, so no wrap.
                  if (w_grant_fetch)
                     r_starve <= '0;
                  else if (f_req)
                     r_starve <= r_starve + 1'b1;
               end
            end
            ACCESS: begin
               if (r_cnt == CNT_LAST) begin
                  r_state <= DONE;
                  if (r_mem_read) begin
                     if (r_gid) r_d_rdata <= mem_rdata;
                     else       r_f_rdata <= mem_rdata;
                  end
                  if (r_gid) r_d_ack <= 1'b1;
                  else       r_f_ack <= 1'b1;
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 2'd0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
                  r_mem_oe    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_gid   <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign f_ack        = r_f_ack;
   assign d_ack        = r_d_ack;
   assign f_rdata      = r_f_rdata;
   assign d_rdata      = r_d_rdata;
   assign mem_read     = r_mem_read;
   assign mem_write    = r_mem_write;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign mem_wdata_oe = r_mem_oe;
   assign busy         = r_busy;
   assign grant_id     = r_gid;
endmodule
